instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Producer side of the decode interface. Holds the architectural PC and fetches one 32-bit
//  instruction per fetch phase from instruction memory over a req/ack handshake.
//  Presents inst, curr_pc_fd and next_pc_fd, registered and stable, to instruction_decode.
//  Applies PC redirects from the jump/branch resolution stage.
// PARAMETERS
//  XLEN          32            datapath/PC width (core_general.vh value)
//  RESET_VECTOR  {XLEN{1'b0}}  PC after reset; bits [1:0] must be 0
//  NOP_INST      32'h0000_0013 inst value after reset (addi x0,x0,0)
// PORTS
//  clk            in   1     core clock
//  rst            in   1     reset, synchronous, active-high
//  phase_fetch    in   1     start-fetch strobe from the phase sequencer
//  redirect_valid in   1     take redirect_pc as the next fetch PC
//  redirect_pc    in   XLEN  redirect target; bits [1:0] ignored (treated as 0)
//  imem_req       out  1     instruction memory request, held until ack
//  imem_addr      out  XLEN  fetch address, stable while imem_req=1
//  imem_ack       in   1     memory response valid; sampled only in REQ
//  imem_rdata     in   32    instruction word, valid with imem_ack
//  inst           out  32    fetched instruction (to decode)
//  curr_pc_fd     out  XLEN  PC of inst
//  next_pc_fd     out  XLEN  curr_pc_fd + 4
//  fetch_done     out  1     one-cycle pulse: inst/pc outputs updated this cycle
//  stall_fetch    out  1     high while a fetch is outstanding (state REQ)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, any state): state<=IDLE, pc<=RESET_VECTOR, imem_req=0,
//   fetch_done=0, inst=NOP_INST, curr_pc_fd=next_pc_fd=RESET_VECTOR, pending redirect cleared.
//   Reset during REQ abandons the request; a late imem_ack is then ignored.
//  FSM states: IDLE, REQ, DONE. All outputs registered or decoded from state.
//  IDLE: if phase_fetch -> REQ, imem_addr<=fetch PC (below). Otherwise stay.
//   Redirect in IDLE without phase_fetch: pc<={redirect_pc[XLEN-1:2],2'b00}.
//   Redirect and phase_fetch together: redirect wins; fetch address = redirect target.
//  REQ: imem_req=1, imem_addr constant. phase_fetch ignored. On imem_ack:
//   inst<=imem_rdata, curr_pc_fd<=imem_addr, next_pc_fd<=imem_addr+4, -> DONE.
//   pc<=pending redirect target if one is held, else imem_addr+4.
//   Redirect arriving during REQ is latched into a single pending register;
//   a later one overwrites it (last wins). It never alters the outstanding address.
//   Redirect in the same cycle as imem_ack counts as pending and is applied.
//  DONE: fetch_done=1 for exactly this cycle; imem_req=0; -> IDLE.
//   Redirect in DONE is applied to pc as in IDLE. phase_fetch in DONE is ignored.
//  Latency: phase_fetch at edge N -> imem_req high from N+1. imem_ack sampled at edge M ->
//   outputs updated and fetch_done high in cycle M+1. Minimum 3 cycles per fetch.
//  Arithmetic: pc+4 is modulo 2^XLEN; all-ones-page PC wraps to 0 with no flag.
//  Outputs inst/curr_pc_fd/next_pc_fd hold their value between fetches.
//  stall_fetch = (state==REQ).
// TESTING
//  1 rst, then phase_fetch, ack after 1 cycle with rdata=32'h00500093 -> imem_addr=0,
//    inst=32'h00500093, curr_pc_fd=0, next_pc_fd=4, fetch_done for exactly 1 cycle.
//  2 Three back-to-back fetches, ack delays 0/3/7 cycles -> addresses 0,4,8;
//    imem_addr stable while req high; stall_fetch matches REQ.
//  3 Redirect 32'h0000_0103 with phase_fetch in IDLE -> imem_addr=32'h0000_0100,
//    next_pc_fd=32'h0000_0104.
//  4 Redirects to 0x200 then 0x300 during REQ at 0x10 -> fetch at 0x10 completes,
//    next_pc_fd=0x14, following fetch from 0x300.
//  5 rst asserted mid-REQ, then stray imem_ack -> imem_req low next cycle, no fetch_done,
//    inst=32'h00000013, next fetch from RESET_VECTOR.
//  6 pc=32'hFFFF_FFFC fetch -> next_pc_fd=0, next fetch address 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instruction_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch unit: holds the architectural PC, fetches one word per fetch phase over
// the imem req/ack bus and presents registered inst/PC values to decode.
// Redirects that arrive while a fetch is outstanding are parked in a single
// pending slot (last one wins) and take effect when that fetch completes.
module instruction_fetch #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]     NOP_INST     = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       phase_fetch,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    instruction_fetch_if.master        imem,
    output logic [31:0]                inst,
    output logic [XLEN-1:0]            curr_pc_fd,
    output logic [XLEN-1:0]            next_pc_fd,
    output logic                       fetch_done,
    output logic                       stall_fetch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            pend_vld_q, pend_vld_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] curr_q, curr_d;
    logic [XLEN-1:0] next_q, next_d;

    logic [XLEN-1:0] redir_aligned;
    logic [XLEN-1:0] addr_plus4;

    assign redir_aligned = redirect_pc & ALIGN_MASK;
    assign addr_plus4    = addr_q + PC_STEP;

    // Next-state and datapath update for the IDLE -> REQ -> DONE fetch sequence
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        inst_d     = inst_q;
        curr_d     = curr_q;
        next_d     = next_q;

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redir_aligned;
                end
                if (phase_fetch) begin
                    // A redirect in the same cycle wins over the held PC.
                    addr_d  = redirect_valid ? redir_aligned : pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                // The outstanding address is never touched; redirects are parked.
                if (redirect_valid) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = redir_aligned;
                end
                if (imem.imem_ack) begin
                    inst_d     = imem.imem_rdata;
                    curr_d     = addr_q;
                    next_d     = addr_plus4;
                    if (redirect_valid) begin
                        pc_d = redir_aligned;
                    end else if (pend_vld_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = addr_plus4;
                    end
                    pend_vld_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (redirect_valid) begin
                    pc_d = redir_aligned;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset restores the post-reset architectural view
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= RESET_VECTOR;
            inst_q     <= NOP_INST;
            curr_q     <= RESET_VECTOR;
            next_q     <= RESET_VECTOR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
            inst_q     <= inst_d;
            curr_q     <= curr_d;
            next_q     <= next_d;
        end
    end

    // Outputs are either registers or decoded directly from the state
    always_comb begin
        imem.imem_req  = (state_q == REQ);
        imem.imem_addr = addr_q;
        stall_fetch    = (state_q == REQ);
        fetch_done     = (state_q == DONE);
        inst           = inst_q;
        curr_pc_fd     = curr_q;
        next_pc_fd     = next_q;
    end

endmodule
